// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   // Width of a register index / opcode field in the 5-stage core.
   localparam int REG_W = 5;

   // Opcodes the controller needs to recognise.
   localparam logic [REG_W-1:0] OPC_NOP  = 5'b11111;
   localparam logic [REG_W-1:0] OPC_LOAD = 5'b00100;
   localparam logic [REG_W-1:0] OPC_JUMP = 5'b01000;

   // Controller states; the encoding is visible on state_o.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_REDIRECT = 2'd3
   } hz_state_t;

   // Pipeline control bundle driven every cycle.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_en;
   } hz_ctrl_t;

   // Control patterns: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}.
   // Flush cases keep ifid_en high; the flush takes precedence in the register.
   localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam hz_ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   localparam hz_ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam hz_ctrl_t CTRL_FLUSH1 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_load_use_det.sv
// Load-use detector: a load in EX whose destination feeds the instruction in ID.
module hazard_load_use_det
   import hazard_pkg::*;
#(
   parameter logic [REG_W-1:0] NOP_OPCODE  = OPC_NOP,
   parameter logic [REG_W-1:0] LOAD_OPCODE = OPC_LOAD
) (
   input  logic [REG_W-1:0] id_opcode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] ex_opcode,
   input  logic [REG_W-1:0] ex_rt,
   output logic             load_use
);

   // r0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign load_use = (ex_opcode == LOAD_OPCODE) &&
                     (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt)) &&
                     (id_opcode != NOP_OPCODE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and memory-wait holds for the
// 5-stage core. Optional performance counters are enabled by defining
// HAZARD_PERF_CNT_EN (adds stall_cycles and flush_count outputs).
//
// Memory handshake: mem_req marks the cycle the MEM stage starts an access;
// mem_ack marks completion. An ack in the request cycle means no wait at all;
// otherwise the pipeline is held until the first cycle mem_ack is high.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter logic [REG_W-1:0] NOP_OPCODE  = OPC_NOP,
   parameter logic [REG_W-1:0] LOAD_OPCODE = OPC_LOAD,
   parameter logic [REG_W-1:0] JUMP_OPCODE = OPC_JUMP,
   parameter int               LU_STALL    = 1,
   parameter int               MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [REG_W-1:0] id_opcode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] ex_opcode,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ack,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             mem_err,
   output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count
`endif
);

   localparam int              TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [1:0]       LU_INIT  = 2'(LU_STALL - 1);

   hz_state_t        state_q, state_d;
   logic [1:0]       lu_cnt_q, lu_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             mem_err_q, mem_err_d;
   hz_ctrl_t         ctrl;
   logic             load_use;
   logic             mem_stall;

   hazard_load_use_det #(
      .NOP_OPCODE  (NOP_OPCODE),
      .LOAD_OPCODE (LOAD_OPCODE)
   ) u_lu_det (
      .id_opcode (id_opcode),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .ex_opcode (ex_opcode),
      .ex_rt     (ex_rt),
      .load_use  (load_use)
   );

   assign mem_stall = mem_req & ~mem_ack;

   // Next-state and pipeline control; Reset forces the safe control pattern.
   always_comb begin
      state_d   = state_q;
      lu_cnt_d  = lu_cnt_q;
      tmo_cnt_d = tmo_cnt_q;
      mem_err_d = mem_err_q;
      ctrl      = CTRL_RUN;
      if (Reset) begin
         ctrl = CTRL_RESET;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (mem_stall) begin
                  ctrl      = CTRL_HOLD;
                  state_d   = ST_MEM_WAIT;
                  tmo_cnt_d = '0;
               end else if (ex_branch_taken) begin
                  ctrl    = CTRL_BRANCH;
                  state_d = ST_REDIRECT;
               end else if (load_use) begin
                  ctrl = CTRL_LU;
                  // A single-cycle stall resolves itself: next cycle EX holds a bubble.
                  if (LU_STALL > 1) begin
                     state_d  = ST_LU_STALL;
                     lu_cnt_d = LU_INIT;
                  end
               end else if (id_opcode == JUMP_OPCODE) begin
                  ctrl = CTRL_FLUSH1;
               end
            end
            ST_LU_STALL: begin
               if (mem_stall) begin
                  // The memory wait takes over; lu_cnt is kept and resumed after the ack.
                  ctrl      = CTRL_HOLD;
                  state_d   = ST_MEM_WAIT;
                  tmo_cnt_d = '0;
               end else begin
                  ctrl = CTRL_LU;
                  if (lu_cnt_q <= 2'd1) begin
                     lu_cnt_d = 2'd0;
                     state_d  = ST_RUN;
                  end else begin
                     lu_cnt_d = lu_cnt_q - 2'd1;
                  end
               end
            end
            ST_MEM_WAIT: begin
               // EX is frozen here, so a taken branch is simply seen again later.
               ctrl = CTRL_HOLD;
               if (tmo_cnt_q != '1) begin
                  tmo_cnt_d = tmo_cnt_q + TMO_ONE;
               end
               if (mem_ack) begin
                  state_d = (lu_cnt_q != 2'd0) ? ST_LU_STALL : ST_RUN;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  // Abandon the wait; a pending load-use stall is dropped with it.
                  mem_err_d = 1'b1;
                  lu_cnt_d  = 2'd0;
                  state_d   = ST_RUN;
               end
            end
            ST_REDIRECT: begin
               // Squash the wrong-path fetch made during the redirect cycle.
               ctrl    = CTRL_FLUSH1;
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // State, counters and sticky error register.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= ST_RUN;
         lu_cnt_q  <= 2'd0;
         tmo_cnt_q <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lu_cnt_q  <= lu_cnt_d;
         tmo_cnt_q <= tmo_cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign pc_en      = ctrl.pc_en;
   assign ifid_en    = ctrl.ifid_en;
   assign ifid_flush = ctrl.ifid_flush;
   assign idex_flush = ctrl.idex_flush;
   assign exmem_en   = ctrl.exmem_en;
   assign mem_err    = mem_err_q;
   assign state_o    = state_q;

`ifdef HAZARD_PERF_CNT_EN
   // Free-running stall and IF/ID flush counters; both wrap naturally.
   always_ff @(posedge clk) begin
      if (Reset) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         if (!ctrl.pc_en) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (ctrl.ifid_flush) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (load-use stall of 1 and of 3 cycles)
// share one stimulus stream; a reference model predicts every output cycle.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   localparam int MEM_TIMEOUT = 16;
`ifdef HAZARD_PERF_CNT_EN
   localparam int W = 72;
`else
   localparam int W = 8;
`endif

   typedef struct packed {
      logic             rst;
      logic [REG_W-1:0] id_op;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] ex_op;
      logic [REG_W-1:0] ex_rt;
      logic             br;
      logic             req;
      logic             ack;
   } stim_t;

   // Model bookkeeping: outstanding stall cycles, wait length, pending redirect.
   typedef struct {
      bit          in_wait;
      int          waited;
      bit          redirect;
      int          lu_left;
      bit          err;
      int unsigned stalls;
      int unsigned flushes;
   } mdl_t;

   logic             clk = 1'b0;
   logic             Reset;
   logic [REG_W-1:0] id_opcode, id_rs, id_rt, ex_opcode, ex_rt;
   logic             ex_branch_taken, mem_req, mem_ack;
   logic [1:0]       pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, mem_err;
   logic [1:0]       state_o [2];
   logic [31:0]      stall_cycles [2];
   logic [31:0]      flush_count [2];

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   mdl_t         mdl [2];
   int           n_vec = 0;
   int           n_err = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   hazard_ctrl #(.LU_STALL(1), .MEM_TIMEOUT(MEM_TIMEOUT)) dut1 (
      .clk(clk), .Reset(Reset),
      .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_opcode(ex_opcode), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
      .idex_flush(idex_flush[0]), .exmem_en(exmem_en[0]), .mem_err(mem_err[0]),
      .state_o(state_o[0])
`ifdef HAZARD_PERF_CNT_EN
     ,.stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
`endif
   );

   hazard_ctrl #(.LU_STALL(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut3 (
      .clk(clk), .Reset(Reset),
      .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_opcode(ex_opcode), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ack(mem_ack),
      .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
      .idex_flush(idex_flush[1]), .exmem_en(exmem_en[1]), .mem_err(mem_err[1]),
      .state_o(state_o[1])
`ifdef HAZARD_PERF_CNT_EN
     ,.stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
`endif
   );

`ifndef HAZARD_PERF_CNT_EN
   assign stall_cycles[0] = 32'd0;
   assign stall_cycles[1] = 32'd0;
   assign flush_count[0]  = 32'd0;
   assign flush_count[1]  = 32'd0;
`endif

   // ---------------- reference model ----------------
   function automatic void mdl_step(input mdl_t m, input int lus, input stim_t s,
                                    output logic [W-1:0] e, output mdl_t n);
      logic [4:0] c;   // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}
      logic [1:0] st;
      bit         lu, stall_mem;
      n  = m;
      st = m.in_wait ? 2'd2 : (m.redirect ? 2'd3 : ((m.lu_left > 0) ? 2'd1 : 2'd0));
      lu = (s.ex_op == OPC_LOAD) && (s.ex_rt != 0) &&
           ((s.ex_rt == s.rs) || (s.ex_rt == s.rt)) && (s.id_op != OPC_NOP);
      stall_mem = s.req && !s.ack;
      c = 5'b11001;
      if (s.rst) begin
         c = 5'b00110;
         n = '{default: 0};
      end else if (m.in_wait) begin
         c = 5'b00000;
         n.waited = m.waited + 1;
         if (s.ack) begin
            n.in_wait = 0;
         end else if (n.waited == MEM_TIMEOUT) begin
            n.err = 1; n.in_wait = 0; n.lu_left = 0;
         end
      end else if (m.redirect) begin
         c = 5'b11101;
         n.redirect = 0;
      end else if (m.lu_left > 0) begin
         if (stall_mem) begin
            c = 5'b00000; n.in_wait = 1; n.waited = 0;
         end else begin
            c = 5'b00011; n.lu_left = m.lu_left - 1;
         end
      end else begin
         if (stall_mem) begin
            c = 5'b00000; n.in_wait = 1; n.waited = 0;
         end else if (s.br) begin
            c = 5'b11111; n.redirect = 1;
         end else if (lu) begin
            c = 5'b00011; n.lu_left = lus - 1;
         end else if (s.id_op == OPC_JUMP) begin
            c = 5'b11101;
         end
      end
      if (!s.rst) begin
         if (!c[4]) n.stalls  = m.stalls + 1;
         if (c[2])  n.flushes = m.flushes + 1;
      end
`ifdef HAZARD_PERF_CNT_EN
      e = {st, c, m.err, m.stalls, m.flushes};
`else
      e = {st, c, m.err};
`endif
   endfunction

   function automatic logic [W-1:0] actual(input int i);
`ifdef HAZARD_PERF_CNT_EN
      return {state_o[i], pc_en[i], ifid_en[i], ifid_flush[i], idex_flush[i],
              exmem_en[i], mem_err[i], stall_cycles[i], flush_count[i]};
`else
      return {state_o[i], pc_en[i], ifid_en[i], ifid_flush[i], idex_flush[i],
              exmem_en[i], mem_err[i]};
`endif
   endfunction

   // ---------------- driver ----------------
   function automatic stim_t mk(input logic rst, input logic [4:0] id_op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] ex_op, input logic [4:0] exrt,
                                input logic br, input logic req, input logic ack);
      stim_t s;
      s.rst = rst; s.id_op = id_op; s.rs = rs; s.rt = rt;
      s.ex_op = ex_op; s.ex_rt = exrt; s.br = br; s.req = req; s.ack = ack;
      return s;
   endfunction

   function automatic stim_t quiet();
      return mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic logic [4:0] pick_op();
      case ($urandom_range(0, 3))
         0:       return OPC_NOP;
         1:       return OPC_LOAD;
         2:       return OPC_JUMP;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst   = ($urandom_range(0, 199) == 0);
      s.id_op = pick_op();
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.ex_op = ($urandom_range(0, 1) == 0) ? OPC_LOAD : pick_op();
      s.ex_rt = 5'($urandom_range(0, 3));
      s.br    = ($urandom_range(0, 7) == 0);
      s.req   = ($urandom_range(0, 5) == 0);
      s.ack   = ($urandom_range(0, 4) == 0);
      return s;
   endfunction

   task automatic drive(input stim_t s);
      logic [W-1:0] e0, e1;
      mdl_t         n0, n1;
      @(posedge clk);
      #1;
      Reset = s.rst; id_opcode = s.id_op; id_rs = s.rs; id_rt = s.rt;
      ex_opcode = s.ex_op; ex_rt = s.ex_rt; ex_branch_taken = s.br;
      mem_req = s.req; mem_ack = s.ack;
      mdl_step(mdl[0], 1, s, e0, n0);
      mdl_step(mdl[1], 3, s, e1, n1);
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
      mdl[0] = n0;
      mdl[1] = n1;
   endtask

   task automatic quiet_cycles(input int n);
      for (int i = 0; i < n; i++) drive(quiet());
   endtask

   // ---------------- scoreboard / monitor ----------------
   initial begin
      logic [W-1:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            a = actual(0);
            n_vec++;
            if (a !== e) begin
               n_err++;
               $display("FAIL lu1_outputs t=%0t actual=%h required=%h", $time, a, e);
            end
         end
         if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            a = actual(1);
            n_vec++;
            if (a !== e) begin
               n_err++;
               $display("FAIL lu3_outputs t=%0t actual=%h required=%h", $time, a, e);
            end
         end
      end
   end

   // ---------------- stimulus + report ----------------
   initial begin
      Reset = 1'b1; id_opcode = '0; id_rs = '0; id_rt = '0; ex_opcode = OPC_NOP;
      ex_rt = '0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      mdl[0] = '{default: 0};
      mdl[1] = '{default: 0};

      // Reset state observed while Reset is still held.
      drive(mk(1'b1, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0, 1'b0));
      quiet_cycles(1);
      // Load-use on rs, then the same with a load to r0 (no stall).
      drive(mk(1'b0, 5'd1, 5'd5, 5'd2, OPC_LOAD, 5'd5, 1'b0, 1'b0, 1'b0));
      quiet_cycles(3);
      drive(mk(1'b0, 5'd1, 5'd0, 5'd2, OPC_LOAD, 5'd0, 1'b0, 1'b0, 1'b0));
      quiet_cycles(1);
      // Taken branch, then a jump.
      drive(mk(1'b0, 5'd1, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b1, 1'b0, 1'b0));
      quiet_cycles(2);
      drive(mk(1'b0, OPC_JUMP, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0, 1'b0));
      quiet_cycles(1);
      // Request with immediate ack: no stall.
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b1, 1'b1));
      // Memory wait acknowledged after four cycles.
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b1, 1'b0));
      quiet_cycles(3);
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0, 1'b1));
      quiet_cycles(2);
      // Memory wait that never completes: timeout and sticky error.
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b1, 1'b0));
      quiet_cycles(20);
      // Memory wait and taken branch together; branch honoured after the ack.
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < 2; i++) drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b1, 1'b0, 1'b0));
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b1, 1'b0, 1'b1));
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b1, 1'b0, 1'b0));
      quiet_cycles(2);
      // Reset in the middle of a memory wait.
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b1, 1'b0));
      quiet_cycles(2);
      drive(mk(1'b1, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0, 1'b0));
      quiet_cycles(2);
      // Load-use stall interrupted by a memory wait, then resumed.
      drive(mk(1'b0, 5'd1, 5'd3, 5'd7, OPC_LOAD, 5'd7, 1'b0, 1'b0, 1'b0));
      drive(mk(1'b0, 5'd1, 5'd3, 5'd7, OPC_LOAD, 5'd7, 1'b0, 1'b1, 1'b0));
      quiet_cycles(2);
      drive(mk(1'b0, 5'd0, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0, 1'b1));
      quiet_cycles(4);

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) drive(rand_stim());
      quiet_cycles(2);

      // Let the monitor drain; leftovers mean missing output cycles.
      for (int i = 0; i < 20 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) @(posedge clk);
      @(posedge clk);
      if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
         n_err++;
         $display("FAIL drain pending=%0d/%0d required=0/0", exp_q0.size(), exp_q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
